// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_pkg
// Description : Shared types and constants for the byte-stream program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package program_loader_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int BYTES_PER_WORD    = 4;
   localparam int NUM_WORDS_DEFAULT = 32;
   localparam int IMAGE_BYTES       = NUM_WORDS_DEFAULT * BYTES_PER_WORD;

endpackage : program_loader_pkg
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Assembles a byte stream into a flat instruction image and
//               releases the core once the image is complete.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
   import program_loader_pkg::*;
#(
   parameter int NUM_WORDS  = 32,
   parameter int WORD_WIDTH = 32
) (
   input  logic                                           clk,
   input  logic                                           rstn,
   input  logic                                           start,
   input  logic                                           in_valid,
   input  logic [7:0]                                     in_data,
   input  logic                                           in_last,
   output logic                                           in_ready,
   output logic [NUM_WORDS*WORD_WIDTH-1:0]                i_memory_input,
   output logic [$clog2(NUM_WORDS*BYTES_PER_WORD):0]      byte_count,
   output logic                                           load_done,
   output logic                                           core_run
);

   localparam int                c_IMAGE_BYTES = NUM_WORDS * BYTES_PER_WORD;
   localparam int                c_IDX_W       = $clog2(c_IMAGE_BYTES);
   localparam int                c_CNT_W       = c_IDX_W + 1;
   localparam logic [c_CNT_W-1:0] c_LAST_IDX   = c_CNT_W'(c_IMAGE_BYTES - 1);

   state_t                           r_state;
   state_t                           w_next_state;
   logic                             w_in_ready;
   logic                             w_xfer;
   logic                             w_clear;
   logic                             w_at_end;
   logic [NUM_WORDS*WORD_WIDTH-1:0]  r_image;
   logic [c_CNT_W-1:0]               r_count;

   assign w_xfer   = in_valid && w_in_ready;
   assign w_at_end = (r_count == c_LAST_IDX);
   // A (re)load request is honoured from IDLE or DONE, never mid-load.
   assign w_clear  = start && (r_state != LOAD);

   always_ff @(posedge clk) begin
      if (rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_in_ready   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next_state = LOAD;
            end
         end
         LOAD: begin
            w_in_ready = 1'b1;
            if (in_valid && (in_last || w_at_end)) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            if (start) begin
               w_next_state = LOAD;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Byte k lands at bits [8k+7:8k], giving little-endian words.
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_image <= '0;
         r_count <= '0;
      end else if (w_clear) begin
         r_image <= '0;
         r_count <= '0;
      end else if (w_xfer) begin
         r_image[{r_count[c_IDX_W-1:0], 3'b000} +: 8] <= in_data;
         r_count                                      <= r_count + 1'b1;
      end
   end

   assign in_ready       = w_in_ready;
   assign i_memory_input = r_image;
   assign byte_count     = r_count;
   assign load_done      = (r_state == DONE);
   assign core_run       = (r_state == DONE);

endmodule : program_loader
`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream neighbour of the single-cycle core.
- Receives a program image as a byte stream over a valid/ready handshake and assembles it into the flat 1024-bit instruction image the core's instruction memory consumes.
- Holds the core idle until the load completes, then asserts a run enable.
- The integrator drives the core's reset from core_run, so the core starts fetching from PC 0 on a fully loaded image.

Parameters:
- NUM_WORDS, 32: instruction words in the image.
- WORD_WIDTH, 32: bits per instruction word; fixed at 32 (4 bytes per word).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rstn  input  1  synchronous, active-high reset. The name is kept for codebase consistency; asserted = 1.
- start  input  1  one-cycle request to begin a (re)load.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_last  input  1  marks the final byte of the image; qualified by in_valid.
- in_ready  output  1  loader accepts a byte this cycle.
- i_memory_input  output  NUM_WORDS*WORD_WIDTH  assembled image; word w at bits [32w+31:32w] (byte address 4w).
- byte_count  output  $clog2(NUM_WORDS*4)+1  bytes accepted in the current load.
- load_done  output  1  image complete and stable.
- core_run  output  1  core may execute; low forces the core into reset via the integrator.

Behaviour:
- States: IDLE, LOAD, DONE. The state register is the only control state.
- Reset (rstn=1 at an edge):
  - state=IDLE; i_memory_input=0; byte_count=0; load_done=0; core_run=0.
  - in_ready is 0 in IDLE, so it is 0 after reset.
  - Applies from any state, including mid-LOAD; a partial image is discarded.
- IDLE:
  - in_ready=0.
  - start=1 -> LOAD at the next edge. On that same edge i_memory_input is cleared to 0 and byte_count to 0.
- LOAD:
  - in_ready=1, decoded combinationally from the state.
  - Handshake: a byte transfers on an edge where in_valid && in_ready. No transfer otherwise. in_valid may drop freely between bytes.
  - Byte k (k = byte_count before the transfer) is written to i_memory_input[8k+7:8k], so bytes are little-endian within each word. The write and the byte_count increment are registered and visible the cycle after the transfer edge.
  - Exit to DONE at the transfer edge when either in_last=1 or k = NUM_WORDS*4-1.
  - Short image (in_last before 128 bytes, including mid-word): untransferred bytes remain 0.
  - in_last with in_valid=0 is ignored.
  - start during LOAD is ignored.
- DONE:
  - in_ready=0; load_done=1; core_run=1. Both are registered and go high the cycle after the final transfer edge.
  - i_memory_input and byte_count hold.
  - start=1 -> LOAD at the next edge, with the same clear as from IDLE. load_done and core_run fall at that same edge.
- Extra bytes after DONE are never accepted because in_ready=0.
- Zero-length load is not possible: at least one byte must transfer before DONE.
- Simultaneous events: rstn has priority over start and over any transfer.

Decomposition:
- Shared package (program_loader_pkg):
  - state enum typedef {IDLE, LOAD, DONE};
  - BYTES_PER_WORD=4;
  - IMAGE_BYTES=NUM_WORDS*4 default constant.
- No sub-module is required. Byte write-enable decode and the FSM fit one module of roughly 150 lines.

Test Plan:
- Reset then idle: rstn=1 for 2 cycles, then 0 -> i_memory_input=0, in_ready=0, load_done=0, core_run=0, byte_count=0.
- Full load: start, then 128 bytes with values 0x00..0x7F, in_valid continuous -> word0=0x03020100, word31=0x7F7E7D7C; load_done=1 and core_run=1 the cycle after byte 127; byte_count=128.
- Short load with gaps: bytes 0x13,0x05,0x50,0x00 with in_valid toggled 1/0, in_last on the 4th -> word0=0x00500513, words 1..31=0, byte_count=4, DONE.
- Mid-word last: 6 bytes 0xAA..0xAF, in_last on the 6th -> word1=0x0000AFAE; upper words 0.
- Reload: in DONE, pulse start -> next cycle core_run=0, load_done=0, image=0, in_ready=1. Load 4 bytes -> new word0 correct.
- Reset mid-load: after 10 bytes assert rstn -> all outputs return to reset values; start during LOAD has no effect (byte_count not cleared).
